// File: rtl/clocktamer_pps_pkg.sv
// Shared state encoding, default widths and small helpers for the 1PPS conditioner.
// Latency: none, types and constants only.
// Backpressure: none, no handshaking in this slice.
package clocktamer_pps_pkg;

  // Default width of the period counter and window arithmetic.
  localparam int PPS_CNT_W = 28;

  // Width of the saturating rejected-edge counter.
  localparam int REJECT_W = 8;

  // Encoding 2'd3 is unused and is treated as ACQUIRE by the FSM.
  typedef enum logic [1:0] {
    ST_ACQUIRE  = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_HOLDOVER = 2'd2
  } pps_state_t;

  // Saturating increment for the reject counter.
  function automatic logic [REJECT_W-1:0] sat_inc_rej(input logic [REJECT_W-1:0] v);
    return (v == '1) ? v : v + REJECT_W'(1);
  endfunction

endpackage

// File: rtl/pps_glitch_filter.sv
// Synchronises raw 1PPS and accepts a rising edge only after MIN_WIDTH high samples.
// Latency: edge_evt rises SYNC_STAGES+MIN_WIDTH-1 cycles after the first high sample.
// Backpressure: none, edge_evt is a single-cycle event that must be consumed at once.
module pps_glitch_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_WIDTH   = 8
) (
  input  logic clk,
  input  logic nreset,
  input  logic pps_in,
  output logic edge_evt
);

  // Run counter saturates at MIN_WIDTH, so it must be able to hold that value.
  localparam int RUN_W = $clog2(MIN_WIDTH + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [RUN_W-1:0]       run_cnt;
  logic                   sync_hi;

  assign sync_hi = sync_q[SYNC_STAGES-1];

  // Metastability chain: pps_in enters at bit 0 and leaves at the top bit.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= pps_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Count consecutive high samples; fire once when the run reaches MIN_WIDTH.
  // Saturation holds the counter at MIN_WIDTH, so a long pulse cannot fire
  // again until a low sample clears the run.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      run_cnt  <= '0;
      edge_evt <= 1'b0;
    end else begin
      edge_evt <= sync_hi && (run_cnt == RUN_W'(MIN_WIDTH - 1));
      if (!sync_hi) begin
        run_cnt <= '0;
      end else if (run_cnt != RUN_W'(MIN_WIDTH)) begin
        run_cnt <= run_cnt + RUN_W'(1);
      end
    end
  end

endmodule

// File: rtl/pps_conditioner.sv
// Qualifies GPS 1PPS: glitch filter, period window check, lock FSM and bounded holdover.
// Latency: pps_out rises SYNC_STAGES+MIN_WIDTH cycles after pps_in is first sampled high.
// Backpressure: none, pps_out is a one-cycle registered pulse the consumer must take.
module pps_conditioner
  import clocktamer_pps_pkg::*;
#(
  parameter int CNT_W        = PPS_CNT_W,
  parameter int SYNC_STAGES  = 2,
  parameter int MIN_WIDTH    = 8,
  parameter int LOCK_COUNT   = 3,
  parameter int MAX_HOLDOVER = 4
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic                pps_in,
  input  logic [CNT_W-1:0]    expected_period,
  input  logic [15:0]         tolerance,
  output logic                pps_out,
  output logic                pps_synth,
  output logic                locked,
  output logic                holdover,
  output logic [1:0]          state,
  output logic [REJECT_W-1:0] reject_count
);

  // Window arithmetic runs one bit wider so the sum and difference cannot wrap.
  localparam int W1     = CNT_W + 1;
  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = $clog2(MAX_HOLDOVER + 1);
  localparam logic [W1-1:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

  logic              edge_evt;
  pps_state_t        st;
  logic [CNT_W-1:0]  p_cnt;
  logic              anchored;
  logic [GOOD_W-1:0] good;
  logic [MISS_W-1:0] miss;

  logic [W1-1:0]     exp_ext;
  logic [W1-1:0]     tol_ext;
  logic [W1-1:0]     p_ext;
  logic [W1-1:0]     lo_raw;
  logic [W1-1:0]     hi_raw;
  logic [W1-1:0]     lo;
  logic [W1-1:0]     hi;
  logic              in_win;
  logic              at_hi;
  logic              past_hi;
  logic [CNT_W-1:0]  tol_reload;

  pps_glitch_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .MIN_WIDTH   (MIN_WIDTH)
  ) u_filter (
    .clk      (clk),
    .nreset   (nreset),
    .pps_in   (pps_in),
    .edge_evt (edge_evt)
  );

  // Acceptance window [lo, hi], clamped to the counter range; recomputed every
  // cycle so a new expected_period or tolerance applies on the next edge check.
  always_comb begin
    exp_ext = W1'(expected_period);
    tol_ext = W1'(tolerance);
    p_ext   = W1'(p_cnt);
    lo_raw  = exp_ext - tol_ext;
    hi_raw  = exp_ext + tol_ext;
    lo      = (tol_ext > exp_ext) ? '0 : lo_raw;
    hi      = (hi_raw > CNT_MAX) ? CNT_MAX : hi_raw;
    in_win  = (p_ext >= lo) && (p_ext <= hi);
    // >= rather than == so that shrinking the window mid-interval still times out.
    at_hi   = (p_ext >= hi);
    past_hi = (p_ext > hi);
  end

  // p_cnt is sampled on the edge after a reload, so the reload cycle itself
  // already counts as one elapsed cycle. That keeps real intervals of exactly
  // expected_period at p_cnt == expected_period, and makes the first synthesised
  // pulse land tolerance cycles late and later ones expected_period apart.
  assign tol_reload = CNT_W'(tol_ext + W1'(1));

  assign state = st;

  // Lock/holdover FSM with p_cnt and all outputs registered together, so state
  // flags change in the same cycle as the pulse that causes the transition.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      st           <= ST_ACQUIRE;
      p_cnt        <= '0;
      anchored     <= 1'b0;
      good         <= '0;
      miss         <= '0;
      pps_out      <= 1'b0;
      pps_synth    <= 1'b0;
      locked       <= 1'b0;
      holdover     <= 1'b0;
      reject_count <= '0;
    end else begin
      pps_out   <= 1'b0;
      pps_synth <= 1'b0;
      if (p_cnt != '1) begin
        p_cnt <= p_cnt + CNT_W'(1);
      end

      case (st)
        ST_LOCKED: begin
          // A real edge on the timeout cycle is in-window and wins over synthesis.
          if (edge_evt) begin
            if (in_win) begin
              pps_out <= 1'b1;
              p_cnt   <= CNT_W'(1);
            end else begin
              reject_count <= sat_inc_rej(reject_count);
            end
          end else if (at_hi) begin
            pps_out   <= 1'b1;
            pps_synth <= 1'b1;
            p_cnt     <= tol_reload;
            miss      <= MISS_W'(1);
            st        <= ST_HOLDOVER;
            locked    <= 1'b0;
            holdover  <= 1'b1;
          end
        end

        ST_HOLDOVER: begin
          if (edge_evt) begin
            if (in_win) begin
              pps_out  <= 1'b1;
              p_cnt    <= CNT_W'(1);
              miss     <= '0;
              st       <= ST_LOCKED;
              locked   <= 1'b1;
              holdover <= 1'b0;
            end else begin
              reject_count <= sat_inc_rej(reject_count);
            end
          end else if (at_hi) begin
            if (miss < MISS_W'(MAX_HOLDOVER)) begin
              pps_out   <= 1'b1;
              pps_synth <= 1'b1;
              p_cnt     <= tol_reload;
              miss      <= miss + MISS_W'(1);
            end else begin
              // Holdover budget spent: drop the anchor and reacquire silently.
              anchored <= 1'b0;
              good     <= '0;
              miss     <= '0;
              st       <= ST_ACQUIRE;
              holdover <= 1'b0;
            end
          end
        end

        default: begin
          // ACQUIRE, and the unused encoding which falls back to ACQUIRE.
          st       <= ST_ACQUIRE;
          locked   <= 1'b0;
          holdover <= 1'b0;
          if (edge_evt) begin
            pps_out <= 1'b1;
            p_cnt   <= CNT_W'(1);
            if (!anchored) begin
              anchored <= 1'b1;
              good     <= '0;
            end else if (in_win) begin
              if (good == GOOD_W'(LOCK_COUNT - 1)) begin
                good   <= '0;
                st     <= ST_LOCKED;
                locked <= 1'b1;
              end else begin
                good <= good + GOOD_W'(1);
              end
            end else begin
              // Out of window: restart the good run from this edge.
              good         <= '0;
              reject_count <= sat_inc_rej(reject_count);
            end
          end else if (past_hi) begin
            anchored <= 1'b0;
            good     <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pps_conditioner.sv
// Scoreboard bench for pps_conditioner: expected pulses queued at drive time, matched on output.
// Latency: one pulse expected SYNC_STAGES+MIN_WIDTH cycles after each qualifying rise.
// Backpressure: none.
module tb_pps_conditioner;
  import clocktamer_pps_pkg::*;

  localparam int LAT = 6;   // SYNC_STAGES(2) + MIN_WIDTH(4)

  logic        clk = 1'b0;
  logic        nreset;
  logic        pps_in;
  logic [27:0] expected_period;
  logic [15:0] tolerance;
  logic        pps_out;
  logic        pps_synth;
  logic        locked;
  logic        holdover;
  logic [1:0]  state;
  logic [7:0]  reject_count;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic       synth;
    logic [1:0] st;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  pps_conditioner #(
    .CNT_W        (28),
    .SYNC_STAGES  (2),
    .MIN_WIDTH    (4),
    .LOCK_COUNT   (3),
    .MAX_HOLDOVER (4)
  ) dut (
    .clk             (clk),
    .nreset          (nreset),
    .pps_in          (pps_in),
    .expected_period (expected_period),
    .tolerance       (tolerance),
    .pps_out         (pps_out),
    .pps_synth       (pps_synth),
    .locked          (locked),
    .holdover        (holdover),
    .state           (state),
    .reject_count    (reject_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Keep the queue in output-time order.
  function automatic void push_exp(input int c, input logic s, input logic [1:0] st);
    exp_t e;
    int i;
    e.cyc = c;
    e.synth = s;
    e.st = st;
    i = 0;
    while (i < sb_q.size() && sb_q[i].cyc <= c) i++;
    sb_q.insert(i, e);
  endfunction

  // Advance to 1 time unit after posedge number c.
  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive a high pulse rising at cycle r for w cycles; optionally expect a pass-through.
  task automatic pulse(input int r, input int w, input logic exp_out, input logic [1:0] st);
    wait_cyc(r);
    pps_in = 1'b1;
    if (exp_out) push_exp(r + 1 + LAT, 1'b0, st);
    wait_cyc(r + w);
    pps_in = 1'b0;
  endtask

  // Output monitor: every pps_out must match the head of the scoreboard.
  always @(negedge clk) begin
    if (pps_synth) check_eq("synth_with_out", pps_out, 1);
    if (pps_out) begin
      check_eq("pps_pending", sb_q.size() > 0, 1);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        check_eq("pps_cycle", cyc, mon_e.cyc);
        check_eq("pps_synth", pps_synth, mon_e.synth);
        check_eq("pps_state", state, mon_e.st);
        check_eq("pps_locked", locked, mon_e.st == ST_LOCKED);
        check_eq("pps_holdover", holdover, mon_e.st == ST_HOLDOVER);
      end
    end
  end

  initial begin
    nreset = 1'b0;
    pps_in = 1'b0;
    expected_period = 28'd1000;
    tolerance = 16'd10;

    // Reset state
    wait_cyc(3);
    check_eq("rst_pps_out", pps_out, 0);
    check_eq("rst_pps_synth", pps_synth, 0);
    check_eq("rst_locked", locked, 0);
    check_eq("rst_holdover", holdover, 0);
    check_eq("rst_state", state, 0);
    check_eq("rst_reject", reject_count, 0);
    wait_cyc(5);
    nreset = 1'b1;

    // Clean pulses every 1000 cycles; lock on the 4th
    pulse(20, 50, 1'b1, ST_ACQUIRE);
    pulse(1020, 50, 1'b1, ST_ACQUIRE);
    pulse(2020, 50, 1'b1, ST_ACQUIRE);
    wait_cyc(2100);
    check_eq("t1_not_locked_yet", locked, 0);
    pulse(3020, 50, 1'b1, ST_LOCKED);
    wait_cyc(3100);
    check_eq("t1_locked", locked, 1);
    check_eq("t1_state", state, ST_LOCKED);

    // 3-cycle glitch is filtered; 20-cycle early pulse is rejected
    pulse(3027 + 400, 3, 1'b0, ST_LOCKED);
    wait_cyc(3460);
    check_eq("t2_glitch_reject", reject_count, 0);
    pulse(4020, 50, 1'b1, ST_LOCKED);
    pulse(4027 + 400, 20, 1'b0, ST_LOCKED);
    wait_cyc(4470);
    check_eq("t2_early_reject", reject_count, 1);
    check_eq("t2_state", state, ST_LOCKED);

    // Input stops: four synthesised pulses, then back to ACQUIRE
    pulse(5020, 50, 1'b1, ST_LOCKED);
    for (int k = 0; k < 4; k++) push_exp(5027 + 1010 + 1000 * k, 1'b1, ST_HOLDOVER);
    wait_cyc(10030);
    check_eq("t3_in_holdover", state, ST_HOLDOVER);
    check_eq("t3_holdover_flag", holdover, 1);
    wait_cyc(10040);
    check_eq("t3_back_acquire", state, ST_ACQUIRE);
    check_eq("t3_holdover_clr", holdover, 0);

    // Relock, drop out, real pulse 995 cycles after the synthesised one
    pulse(11000, 50, 1'b1, ST_ACQUIRE);
    pulse(12000, 50, 1'b1, ST_ACQUIRE);
    pulse(13000, 50, 1'b1, ST_ACQUIRE);
    pulse(14000, 50, 1'b1, ST_LOCKED);
    push_exp(14007 + 1010, 1'b1, ST_HOLDOVER);
    pulse(15017 + 995 - 1 - LAT, 50, 1'b1, ST_LOCKED);
    wait_cyc(16100);
    check_eq("t4_relocked", state, ST_LOCKED);

    // Real edge coincides with the timeout cycle: real pulse only
    pulse(16012 + 1010 - 1 - LAT, 50, 1'b1, ST_LOCKED);
    wait_cyc(17100);
    check_eq("t5_state", state, ST_LOCKED);

    // Reset in holdover 500 cycles after a synthesised pulse
    push_exp(17022 + 1010, 1'b1, ST_HOLDOVER);
    wait_cyc(18531);
    check_eq("t6_pre_state", state, ST_HOLDOVER);
    check_eq("t6_pre_reject", reject_count, 1);
    wait_cyc(18032 + 500);
    nreset = 1'b0;
    wait_cyc(18533);
    check_eq("t6_rst_pps_out", pps_out, 0);
    check_eq("t6_rst_synth", pps_synth, 0);
    check_eq("t6_rst_locked", locked, 0);
    check_eq("t6_rst_holdover", holdover, 0);
    check_eq("t6_rst_state", state, 0);
    check_eq("t6_rst_reject", reject_count, 0);
    wait_cyc(18535);
    nreset = 1'b1;
    pulse(19500, 50, 1'b1, ST_ACQUIRE);

    // Out-of-window interval in ACQUIRE still passes through but counts a reject
    pulse(20100, 50, 1'b1, ST_ACQUIRE);
    wait_cyc(20150);
    check_eq("t7_acq_reject", reject_count, 1);
    pulse(21100, 50, 1'b1, ST_ACQUIRE);

    wait_cyc(21400);
    check_eq("end_state", state, ST_ACQUIRE);
    check_eq("end_sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pps_conditioner.md
# pps_conditioner

Qualifies the raw GPS 1PPS input before it reaches `clock_counter`, whose `one_pps` input is driven by `pps_out`. The block does four things:
- synchronises the input and rejects glitches;
- checks each pulse interval against an expected period in `clk` cycles;
- locks after consecutive good intervals;
- during GPS dropouts, synthesises pulses at the expected interval for a bounded holdover time.

## Interface
Parameters:
- `CNT_W`, 28: width of the period counter, `expected_period` and the window arithmetic.
- `SYNC_STAGES`, 2: depth of the input synchroniser flops.
- `MIN_WIDTH`, 8: number of consecutive synchronised-high cycles needed to accept a rising edge.
- `LOCK_COUNT`, 3: number of consecutive in-window intervals needed to enter LOCKED.
- `MAX_HOLDOVER`, 4: number of synthesised pulses allowed before returning to ACQUIRE.

Ports:
- `clk`  in  1  high-rate reference clock.
- `nreset`  in  1  synchronous, active-low reset.
- `pps_in`  in  1  raw asynchronous 1PPS from the GPS.
- `expected_period`  in  CNT_W  nominal interval in `clk` cycles; quasi-static.
- `tolerance`  in  16  half-width of the acceptance window in cycles.
- `pps_out`  out  1  one-cycle pulse per accepted or synthesised edge.
- `pps_synth`  out  1  high together with `pps_out` only when the pulse is synthesised.
- `locked`  out  1  high in LOCKED.
- `holdover`  out  1  high in HOLDOVER.
- `state`  out  2  current FSM state.
- `reject_count`  out  8  saturating count of rejected edges.

## Operation
Glitch filter:
- `pps_in` passes through `SYNC_STAGES` flops.
- A run counter counts consecutive high samples and clears on any low sample.
- An edge event fires once, in the cycle the run counter reaches `MIN_WIDTH`.
- No further event fires until a low sample has been seen.

Period counter `p_cnt`:
- Counts `clk` cycles since the last anchor, accepted edge or synthesised pulse.
- Saturates at all-ones.

Window arithmetic:
- `lo` = `expected_period` − `tolerance`, clamped at 0.
- `hi` = `expected_period` + `tolerance`, clamped at 2^CNT_W−1.
- Both are computed at CNT_W+1 bits.
- An edge is in-window when `lo` ≤ `p_cnt` ≤ `hi`.

FSM states: ACQUIRE=0, LOCKED=1, HOLDOVER=2 (3 unused; decodes to ACQUIRE).

ACQUIRE:
- Every edge pulses `pps_out` (pass-through).
- First edge with no anchor: set anchor, `p_cnt`←0, `good`←0.
- In-window edge: `good`++, `p_cnt`←0. When `good` reaches `LOCK_COUNT`, go to LOCKED.
- Out-of-window edge: `good`←0, re-anchor, `reject_count`++.
- `p_cnt` > `hi` with no edge: clear anchor and `good`.

LOCKED:
- In-window edge: `pps_out`, `p_cnt`←0.
- Edge with `p_cnt` < `lo`: suppressed, `reject_count`++.
- `p_cnt` == `hi` with no edge: synthesised pulse, `p_cnt`←`tolerance`, `miss`←1, go to HOLDOVER.

HOLDOVER:
- In-window edge: `pps_out`, `p_cnt`←0, `miss`←0, go to LOCKED.
- Early edge: suppressed, `reject_count`++.
- `p_cnt` == `hi` with no edge:
  - if `miss` < `MAX_HOLDOVER`: synthesised pulse, `p_cnt`←`tolerance`, `miss`++;
  - otherwise: no pulse, clear anchor, go to ACQUIRE.

Simultaneous events:
- An edge arriving in the same cycle that `p_cnt` == `hi` counts as a real in-window edge. The real edge wins and no pulse is synthesised.

Parameter changes:
- Changes to `expected_period` or `tolerance` take effect on the next cycle.

## Timing
Reset (`nreset` low at a `clk` edge):
- `pps_out`=0, `pps_synth`=0, `locked`=0, `holdover`=0, `state`=0, `reject_count`=0.
- `p_cnt`=0; anchor, `good`, `miss` and the synchroniser/filter state are cleared.
- Reset mid-holdover aborts immediately with no pulse.

Latency:
- `pps_out` rises exactly `SYNC_STAGES`+`MIN_WIDTH` cycles after the first `clk` edge that samples `pps_in` high.
- The latency is constant, so it does not bias downstream interval counts.

Pulse shape:
- `pps_out` and `pps_synth` are registered and last exactly 1 cycle.
- `state`, `locked` and `holdover` update in the same cycle as the pulse that causes the transition.

Holdover phase:
- The first synthesised pulse lags nominal by `tolerance`.
- Subsequent synthesised pulses occur every `expected_period` cycles.

## Structure
- Package `clocktamer_pps_pkg`: state enum/encoding, the `CNT_W` default, and the `reject_count` width.
- Sub-module `pps_glitch_filter`: synchroniser plus run-length filter; outputs a single-cycle `edge` event.
- The top level holds `p_cnt`, the window compare and the FSM.

## Test plan
Bench settings: `expected_period`=1000, `tolerance`=10, `MIN_WIDTH`=4, `LOCK_COUNT`=3, `MAX_HOLDOVER`=4.

1. Clean pulses every 1000 cycles, width 50:
   - `pps_out` fires for every pulse, each 6 cycles after its rise.
   - `locked`=1 on the 4th pulse.
2. Locked, then a 3-cycle-wide glitch at `p_cnt`=400:
   - No edge event; `reject_count` unchanged.
   - Then a 20-cycle-wide pulse at `p_cnt`=400: `reject_count`=1, no `pps_out`.
3. Locked, then the input stops:
   - `pps_out`+`pps_synth` at `p_cnt`=1010, then every 1000 cycles, four pulses in total.
   - Then `state`=ACQUIRE with no 5th pulse.
4. In holdover, a real pulse arrives at 995 cycles after a synthesised pulse:
   - Real `pps_out` with `pps_synth`=0; `state`=LOCKED.
5. Locked, a real edge event lands exactly at `p_cnt`=1010:
   - A single `pps_out` with `pps_synth`=0; `state` stays LOCKED.
6. `nreset` asserted in HOLDOVER 500 cycles after a synthesised pulse:
   - All outputs 0 next cycle; no synthesised pulse follows.
   - The next real pulse is a pass-through in ACQUIRE.
